// File: rtl/md5_pre_stage_n.sv
// MD5 pre-addition stage: merges multi-lane byte injections into the owned message word and precomputes P = K + D + M.
// Optional padding mask on words 13..15 is enabled by defining MD5_PRE_PADMASK_EN.
module md5_pre_stage_n #(
    parameter int unsigned MSG_INDEX = 0,
    parameter logic [31:0] KONSTANT  = 32'h0,
    parameter int unsigned LANES     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 valid_in,
    input  logic [31:0]          d_in,
    input  logic [LANES-1:0]     lane_vld_in,
    input  logic [6*LANES-1:0]   offset_in,
    input  logic [8*LANES-1:0]   msbyte_in,
    input  logic                 load_in,
    input  logic [31:0]          load_word,
    output logic                 valid_out,
    output logic [LANES-1:0]     lane_vld_out,
    output logic [6*LANES-1:0]   offset_out,
    output logic [8*LANES-1:0]   msbyte_out,
    output logic [31:0]          p_out,
    output logic [31:0]          msg_out
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OFF_W  = 6 * LANES;
    localparam int unsigned MB_W   = 8 * LANES;

    logic [WORD_W-1:0] msg_q, msg_d;
    logic [WORD_W-1:0] p_q, p_d;
    logic              valid_q, valid_d;
    logic [LANES-1:0]  lane_vld_q, lane_vld_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [MB_W-1:0]   msbyte_q, msbyte_d;

    logic [WORD_W-1:0] base_c;
    logic [WORD_W-1:0] m_merge_c;
    logic [WORD_W-1:0] m_next_c;
    logic [LANES-1:0]  lane_hit_c;
    logic [WORD_W-1:0] csa_sum_c;
    logic [WORD_W-1:0] csa_cry_c;
    logic [WORD_W-1:0] p_next_c;

    // A lane hits when valid and its word field addresses this stage.
    always_comb begin
        lane_hit_c = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_hit_c[l] = lane_vld_in[l] && (offset_in[6*l+2 +: 4] == 4'(MSG_INDEX));
        end
    end

    assign base_c = load_in ? load_word : msg_q;

    // Ascending lane order so the highest-numbered lane wins a shared byte.
    always_comb begin
        m_merge_c = base_c;
        for (int unsigned l = 0; l < LANES; l++) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (lane_hit_c[l] && (offset_in[6*l +: 2] == 2'(b))) begin
                    m_merge_c[8*b +: 8] = msbyte_in[8*l +: 8];
                end
            end
        end
    end

`ifdef MD5_PRE_PADMASK_EN
    // Words 13..15 carry padding/length fields with known-zero bits.
    always_comb begin
        m_next_c = m_merge_c;
        if (MSG_INDEX == 15) begin
            m_next_c = '0;
        end else if (MSG_INDEX == 14) begin
            m_next_c = {23'h0, m_merge_c[8:3], 3'h0};
        end else if (MSG_INDEX == 13) begin
            m_next_c = {m_merge_c[31:7], 7'h0};
        end
    end
`else
    assign m_next_c = m_merge_c;
`endif

    // 3:2 compressor then a single carry-propagate adder; top carry dropped.
    assign csa_sum_c = KONSTANT ^ d_in ^ m_next_c;
    assign csa_cry_c = {(KONSTANT[30:0] & d_in[30:0])
                      | (KONSTANT[30:0] & m_next_c[30:0])
                      | (d_in[30:0] & m_next_c[30:0]), 1'b0};
    assign p_next_c  = csa_sum_c + csa_cry_c;

    // Bubbles advance valid only; data registers keep their last beat.
    always_comb begin
        valid_d    = valid_q;
        msg_d      = msg_q;
        p_d        = p_q;
        lane_vld_d = lane_vld_q;
        offset_d   = offset_q;
        msbyte_d   = msbyte_q;
        if (en) begin
            valid_d = valid_in;
            if (valid_in) begin
                msg_d      = m_next_c;
                p_d        = p_next_c;
                lane_vld_d = lane_vld_in;
                offset_d   = offset_in;
                msbyte_d   = msbyte_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            msg_q      <= '0;
            p_q        <= '0;
            lane_vld_q <= '0;
            offset_q   <= '0;
            msbyte_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            msg_q      <= msg_d;
            p_q        <= p_d;
            lane_vld_q <= lane_vld_d;
            offset_q   <= offset_d;
            msbyte_q   <= msbyte_d;
        end
    end

    assign valid_out    = valid_q;
    assign msg_out      = msg_q;
    assign p_out        = p_q;
    assign lane_vld_out = lane_vld_q;
    assign offset_out   = offset_q;
    assign msbyte_out   = msbyte_q;

endmodule

// File: tb/tb_md5_pre_stage_n.sv
// Bench for md5_pre_stage_n: three stage instances (words 3, 0, 14) share stimulus and are
// checked against a byte-array reference model, directed vectors and hand sequences.
module tb_md5_pre_stage_n;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        valid_in;
    logic [31:0] d_in;
    logic [1:0]  lane_vld_in;
    logic [11:0] offset_in;
    logic [15:0] msbyte_in;
    logic        load_in;
    logic [31:0] load_word;

    logic        v_o   [3];
    logic [1:0]  lv_o  [3];
    logic [11:0] off_o [3];
    logic [15:0] mb_o  [3];
    logic [31:0] p_o   [3];
    logic [31:0] msg_o [3];

    int n_cmp = 0;
    int n_bad = 0;

    md5_pre_stage_n #(.MSG_INDEX(3), .KONSTANT(32'h1000_0000), .LANES(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .d_in(d_in),
        .lane_vld_in(lane_vld_in), .offset_in(offset_in), .msbyte_in(msbyte_in),
        .load_in(load_in), .load_word(load_word), .valid_out(v_o[0]),
        .lane_vld_out(lv_o[0]), .offset_out(off_o[0]), .msbyte_out(mb_o[0]),
        .p_out(p_o[0]), .msg_out(msg_o[0]));

    md5_pre_stage_n #(.MSG_INDEX(0), .KONSTANT(32'hFFFF_FFFF), .LANES(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .d_in(d_in),
        .lane_vld_in(lane_vld_in), .offset_in(offset_in), .msbyte_in(msbyte_in),
        .load_in(load_in), .load_word(load_word), .valid_out(v_o[1]),
        .lane_vld_out(lv_o[1]), .offset_out(off_o[1]), .msbyte_out(mb_o[1]),
        .p_out(p_o[1]), .msg_out(msg_o[1]));

    md5_pre_stage_n #(.MSG_INDEX(14), .KONSTANT(32'h0), .LANES(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .d_in(d_in),
        .lane_vld_in(lane_vld_in), .offset_in(offset_in), .msbyte_in(msbyte_in),
        .load_in(load_in), .load_word(load_word), .valid_out(v_o[2]),
        .lane_vld_out(lv_o[2]), .offset_out(off_o[2]), .msbyte_out(mb_o[2]),
        .p_out(p_o[2]), .msg_out(msg_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, one entry per instance.
    logic        m_val [3];
    logic [31:0] m_msg [3];
    logic [31:0] m_p   [3];
    logic [1:0]  m_lv  [3];
    logic [11:0] m_off [3];
    logic [15:0] m_mb  [3];

    function automatic int idx_of(int i);
        case (i)
            0:       return 3;
            1:       return 0;
            default: return 14;
        endcase
    endfunction

    function automatic logic [31:0] k_of(int i);
        case (i)
            0:       return 32'h1000_0000;
            1:       return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    // Next message word from the rules: base word, then lanes 0..1 into a byte array, then mask.
    function automatic logic [31:0] model_m(int idx, logic [31:0] stored);
        logic [7:0]  bytes [4];
        logic [31:0] w;
        int o;
        w = load_in ? load_word : stored;
        for (int k = 0; k < 4; k++) bytes[k] = 8'((w >> (8 * k)) & 32'hFF);
        for (int l = 0; l < 2; l++) begin
            o = int'((offset_in >> (6 * l)) & 12'd63);
            if (lane_vld_in[l] && (o / 4 == idx))
                bytes[o % 4] = 8'((msbyte_in >> (8 * l)) & 16'hFF);
        end
        w = {bytes[3], bytes[2], bytes[1], bytes[0]};
`ifdef MD5_PRE_PADMASK_EN
        if (idx == 15) w = 32'h0;
        else if (idx == 14) w = w & 32'h0000_01F8;
        else if (idx == 13) w = w & 32'hFFFF_FF80;
`endif
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_val[i] = 1'b0; m_msg[i] = '0; m_p[i] = '0;
            m_lv[i] = '0; m_off[i] = '0; m_mb[i] = '0;
        end
    endtask

    task automatic model_edge();
        logic [31:0] nm;
        for (int i = 0; i < 3; i++) begin
            if (en) begin
                m_val[i] = valid_in;
                if (valid_in) begin
                    nm       = model_m(idx_of(i), m_msg[i]);
                    m_msg[i] = nm;
                    m_p[i]   = k_of(i) + d_in + nm;
                    m_lv[i]  = lane_vld_in;
                    m_off[i] = offset_in;
                    m_mb[i]  = msbyte_in;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid[%0d]", i), 32'(v_o[i]), 32'(m_val[i]));
            chk($sformatf("msg[%0d]", i), msg_o[i], m_msg[i]);
            chk($sformatf("p[%0d]", i), p_o[i], m_p[i]);
            chk($sformatf("lane_vld[%0d]", i), 32'(lv_o[i]), 32'(m_lv[i]));
            chk($sformatf("offset[%0d]", i), 32'(off_o[i]), 32'(m_off[i]));
            chk($sformatf("msbyte[%0d]", i), 32'(mb_o[i]), 32'(m_mb[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic e, input logic v, input logic ld, input logic [31:0] lw,
                         input logic [31:0] d, input logic [1:0] lv, input logic [11:0] off,
                         input logic [15:0] mb);
        en = e; valid_in = v; load_in = ld; load_word = lw; d_in = d;
        lane_vld_in = lv; offset_in = off; msbyte_in = mb;
    endtask

    task automatic drive_random(input logic e);
        logic [3:0] w0, w1;
        w0 = 4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : (($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 3 : 14)));
        w1 = 4'($urandom_range(0, 1) == 0 ? 3 : $urandom_range(0, 15));
        drive(e, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), $urandom, $urandom,
              2'($urandom_range(0, 3)), {w1, 2'($urandom_range(0, 3)), w0, 2'($urandom_range(0, 3))},
              16'($urandom));
    endtask

    typedef struct {
        logic        v;
        logic        ld;
        logic [31:0] lw;
        logic [31:0] d;
        logic [1:0]  lv;
        logic [11:0] off;
        logic [15:0] mb;
        logic        x_v;
        logic [31:0] x_msg;
        logic [31:0] x_p;
    } vec_t;

    vec_t tbl [5];

    initial begin
        // Expected values below are for the word-3 instance, K = 32'h1000_0000.
        tbl[0] = '{1'b1, 1'b1, 32'h1122_3344, 32'd1, 2'b00, 12'd0, 16'h0, 1'b1, 32'h1122_3344, 32'h2122_3345};
        tbl[1] = '{1'b1, 1'b0, 32'h0, 32'd0, 2'b01, {6'd0, 6'd13}, 16'h00AB, 1'b1, 32'h1122_AB44, 32'h2122_AB44};
        tbl[2] = '{1'b1, 1'b0, 32'h0, 32'd0, 2'b01, {6'd0, 6'd20}, 16'h00FF, 1'b1, 32'h1122_AB44, 32'h2122_AB44};
        tbl[3] = '{1'b1, 1'b0, 32'h0, 32'd0, 2'b11, {6'd12, 6'd12}, 16'h0201, 1'b1, 32'h1122_AB02, 32'h2122_AB02};
        tbl[4] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 32'd7, 2'b11, {6'd12, 6'd12}, 16'h6655, 1'b0, 32'h1122_AB02, 32'h2122_AB02};

        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'hCAFE_F00D, 32'd9, 2'b11, 12'd0, 16'h0);
        model_reset();
        #12;
        check_all();
        step();
        rst_n = 1'b1;

        // Wrap: word-0 stage, stored 0, K=FFFF_FFFF, D=1 -> P=0.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'd1, 2'b00, 12'd0, 16'h0);
        step();
        chk("wrap_p", p_o[1], 32'h0);
        chk("wrap_msg", msg_o[1], 32'h0);

        for (int r = 0; r < 5; r++) begin
            drive(1'b1, tbl[r].v, tbl[r].ld, tbl[r].lw, tbl[r].d, tbl[r].lv, tbl[r].off, tbl[r].mb);
            step();
            chk($sformatf("tbl%0d_valid", r), 32'(v_o[0]), 32'(tbl[r].x_v));
            chk($sformatf("tbl%0d_msg", r), msg_o[0], tbl[r].x_msg);
            chk($sformatf("tbl%0d_p", r), p_o[0], tbl[r].x_p);
        end

        // Padding mask on the word-14 stage.
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0, 2'b00, 12'd0, 16'h0);
        step();
`ifdef MD5_PRE_PADMASK_EN
        chk("pad_msg14", msg_o[2], 32'h0000_01F8);
`else
        chk("pad_msg14", msg_o[2], 32'hFFFF_FFFF);
`endif
        chk("pad_msg3", msg_o[0], 32'hFFFF_FFFF);
        chk("pad_p3", p_o[0], 32'h0FFF_FFFF);

        // Stall: three cycles of toggling inputs with en=0 must not move anything.
        for (int s = 0; s < 3; s++) begin
            drive_random(1'b0);
            step();
            chk("stall_valid", 32'(v_o[0]), 32'd1);
            chk("stall_msg", msg_o[0], 32'hFFFF_FFFF);
            chk("stall_p", p_o[0], 32'h0FFF_FFFF);
        end
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'd0, 2'b00, 12'd0, 16'h0);
        step();
        chk("resume_msg", msg_o[0], 32'h0000_0020);
        chk("resume_p", p_o[0], 32'h1000_0020);

        // Randomised run with a mid-stream asynchronous reset.
        for (int c = 0; c < 400; c++) begin
            drive_random(1'($urandom_range(0, 3) != 0));
            step();
            if (c == 200) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all();
                step();
                rst_n = 1'b1;
                drive(1'b1, 1'b1, 1'b1, 32'h1122_3344, 32'd1, 2'b00, 12'd0, 16'h0);
                step();
                chk("rst_load_msg", msg_o[0], 32'h1122_3344);
                chk("rst_load_p", p_o[0], 32'h2122_3345);
                chk("rst_load_valid", 32'(v_o[0]), 32'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
